// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared types and constants for clk_edge_monitor.
//   mon_state_e  - lock FSM states
//   PRIME_LEN    - cycles of edge masking after reset release; 3, or 5 when
//                  CLK_MON_GLITCH_FILTER_EN adds the majority filter stage
//   DEF_*        - default tolerance, lock count and timeout
package clk_mon_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKING,
        LOCKED,
        LOST
    } mon_state_e;

`ifdef CLK_MON_GLITCH_FILTER_EN
    localparam logic [2:0] PRIME_LEN = 3'd5;
`else
    localparam logic [2:0] PRIME_LEN = 3'd3;
`endif

    localparam int DEF_TOL     = 4;
    localparam int DEF_LOCK_N  = 4;
    localparam int DEF_TIMEOUT = 12582912;  // 1.5 * 2^23

endpackage

// File: rtl/clk_edge_monitor_if.sv
// clk_edge_monitor_if: monitored wave in, edge enables and status out.
//   SLOWCLK      - monitored square wave (asynchronous to CLOCK)
//   RISE / FALL  - one-cycle edge enables
//   HALF_PERIOD  - last valid measured edge-to-edge interval, CLOCK cycles
//   LOCKED/LOST  - lock status
// Modports: master = the monitor, slave = the consumer that supplies SLOWCLK.
interface clk_edge_monitor_if #(
    parameter int CNT_W = 24
);
    logic             SLOWCLK;
    logic             RISE;
    logic             FALL;
    logic [CNT_W-1:0] HALF_PERIOD;
    logic             LOCKED;
    logic             LOST;

    modport master (
        input  SLOWCLK,
        output RISE, FALL, HALF_PERIOD, LOCKED, LOST
    );

    modport slave (
        output SLOWCLK,
        input  RISE, FALL, HALF_PERIOD, LOCKED, LOST
    );
endinterface

// File: rtl/sync_edge_det.sv
// sync_edge_det: synchronizes SLOWCLK into CLOCK and produces registered
// one-cycle RISE/FALL pulses.
//   CLOCK, RESET - system clock, synchronous active-high reset
//   SLOWCLK      - asynchronous input wave
//   edge_nxt     - combinational: a pulse will be registered on this edge
//   RISE, FALL   - registered pulses
// Optional: CLK_MON_GLITCH_FILTER_EN inserts a 3-sample majority filter after
// the synchronizer (latency 3 -> 5 cycles, prime 3 -> 5 cycles).
module sync_edge_det
    import clk_mon_pkg::*;
(
    input  logic CLOCK,
    input  logic RESET,
    input  logic SLOWCLK,
    output logic edge_nxt,
    output logic RISE,
    output logic FALL
);
    logic       s1, s2, s3;
    logic       line;        // synchronized (and optionally filtered) level
    logic [2:0] prime_cnt;
    logic       priming;
    logic       rise_nxt, fall_nxt;

`ifdef CLK_MON_GLITCH_FILTER_EN
    logic [2:0] sh;

    always_ff @(posedge CLOCK) begin
        if (RESET) sh <= '0;
        else       sh <= {sh[1:0], s2};
    end

    // Any level that lasts a single sample never wins the vote.
    assign line = (sh[0] & sh[1]) | (sh[0] & sh[2]) | (sh[1] & sh[2]);
`else
    assign line = s2;
`endif

    // While priming, s3 still tracks the line so that a wave already high at
    // reset release settles without ever looking like an edge.
    assign priming  = (prime_cnt != 3'd0);
    assign rise_nxt = ~priming &  line & ~s3;
    assign fall_nxt = ~priming & ~line &  s3;
    assign edge_nxt = rise_nxt | fall_nxt;

    // NOTE: non-blocking assignments make s1->s2->s3 a real shift chain; with
    // blocking ones the synchronizer would collapse into a single flop.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            prime_cnt <= PRIME_LEN;
            RISE      <= 1'b0;
            FALL      <= 1'b0;
        end else begin
            s1   <= SLOWCLK;
            s2   <= s1;
            s3   <= line;
            RISE <= rise_nxt;
            FALL <= fall_nxt;
            if (priming) prime_cnt <= prime_cnt - 3'd1;
        end
    end
endmodule

// File: rtl/clk_edge_monitor.sv
// clk_edge_monitor: turns a slow divided wave into RISE/FALL clock enables,
// measures its half-period and tracks lock / loss.
//   CLOCK, RESET - system clock, synchronous active-high reset
//   mon          - clk_edge_monitor_if.master (SLOWCLK in; RISE, FALL,
//                  HALF_PERIOD, LOCKED, LOST out)
// Parameters: CNT_W counter width (saturating), TOL match tolerance, LOCK_N
// consecutive matches to lock, TIMEOUT edge-free cycles before LOST.
// Optional: CLK_MON_GLITCH_FILTER_EN (see sync_edge_det).
module clk_edge_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W   = 24,
    parameter int TOL     = DEF_TOL,
    parameter int LOCK_N  = DEF_LOCK_N,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                CLOCK,
    input  logic                RESET,
    clk_edge_monitor_if.master  mon
);
    localparam int              MC_W       = $clog2(LOCK_N + 1);
    localparam logic [CNT_W:0]  TOL_C      = (CNT_W + 1)'(TOL);
    localparam logic [CNT_W:0]  TIMEOUT_C  = (CNT_W + 1)'(TIMEOUT);
    localparam logic [MC_W-1:0] LAST_MATCH = MC_W'(LOCK_N - 1);

    logic             edge_nxt, rise, fall;
    logic [CNT_W-1:0] cnt, meas, half_period;
    logic [CNT_W:0]   cnt_p1, meas_x, hp_x, diff;
    logic [MC_W-1:0]  match_cnt;
    logic             match, timeout, ref_pend, locked, lost;
    mon_state_e       state;

    sync_edge_det u_sync (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .SLOWCLK  (mon.SLOWCLK),
        .edge_nxt (edge_nxt),
        .RISE     (rise),
        .FALL     (fall)
    );

    // One extra bit catches the carry out of an all-ones counter, which then
    // holds (saturates) instead of wrapping.
    assign cnt_p1 = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign meas   = cnt_p1[CNT_W] ? cnt : cnt_p1[CNT_W-1:0];

    // Absolute difference on a widened operand so neither order underflows.
    assign meas_x  = {1'b0, meas};
    assign hp_x    = {1'b0, half_period};
    assign diff    = (meas_x >= hp_x) ? (meas_x - hp_x) : (hp_x - meas_x);
    assign match   = (diff <= TOL_C);
    assign timeout = (cnt_p1 == TIMEOUT_C);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= UNLOCKED;
            cnt         <= '0;
            half_period <= '0;
            match_cnt   <= '0;
            ref_pend    <= 1'b0;
            locked      <= 1'b0;
            lost        <= 1'b0;
        end else begin
            cnt <= edge_nxt ? '0 : meas;
            case (state)
                // The first interval after reset or loss is partial, so that
                // edge only restarts the counter.
                UNLOCKED: begin
                    if (edge_nxt) begin
                        state     <= LOCKING;
                        ref_pend  <= 1'b1;
                        match_cnt <= '0;
                    end
                end
                LOCKING: begin
                    if (edge_nxt) begin
                        half_period <= meas;
                        if (ref_pend) begin
                            ref_pend  <= 1'b0;
                            match_cnt <= '0;
                        end else if (match) begin
                            if (match_cnt == LAST_MATCH) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + MC_W'(1);
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state <= LOST;
                        lost  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (edge_nxt) begin
                        half_period <= meas;
                        if (!match) begin
                            state     <= LOCKING;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state  <= LOST;
                        locked <= 1'b0;
                        lost   <= 1'b1;
                    end
                end
                LOST: begin
                    if (edge_nxt) begin
                        state     <= LOCKING;
                        lost      <= 1'b0;
                        ref_pend  <= 1'b1;
                        match_cnt <= '0;
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                    lost   <= 1'b0;
                end
            endcase
        end
    end

    assign mon.RISE        = rise;
    assign mon.FALL        = fall;
    assign mon.HALF_PERIOD = half_period;
    assign mon.LOCKED      = locked;
    assign mon.LOST        = lost;
endmodule

// File: tb/tb_clk_edge_monitor.sv
// tb_clk_edge_monitor: directed bench for clk_edge_monitor with CNT_W=8,
// TOL=1, LOCK_N=2, TIMEOUT=40. Each SLOWCLK toggle pushes the expected pulse
// (kind, due cycle, HALF_PERIOD, LOCKED, LOST) to a scoreboard queue; a
// negedge monitor pops and compares whenever RISE or FALL is seen.
// Define CLK_MON_GLITCH_FILTER_EN to build and test the filtered variant.
module tb_clk_edge_monitor;

`ifdef CLK_MON_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        bit rise;
        int due;
        int hp;
        bit lk;
        bit lost;
    } exp_t;

    logic CLOCK = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   last_tog = 0;
    exp_t sb[$];
    exp_t cur;

    clk_edge_monitor_if #(.CNT_W(8)) ifc ();

    clk_edge_monitor #(
        .CNT_W   (8),
        .TOL     (1),
        .LOCK_N  (2),
        .TIMEOUT (40)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .mon   (ifc.master)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rise"},   32'(ifc.RISE),        32'd0);
        check({tag, "_fall"},   32'(ifc.FALL),        32'd0);
        check({tag, "_hp"},     32'(ifc.HALF_PERIOD), 32'd0);
        check({tag, "_locked"}, 32'(ifc.LOCKED),      32'd0);
        check({tag, "_lost"},   32'(ifc.LOST),        32'd0);
    endtask

    // Wait gap negedges, toggle SLOWCLK, and queue the pulse it must cause.
    task automatic step(input int gap, input int hp, input bit lk);
        exp_t e;
        repeat (gap) @(negedge CLOCK);
        ifc.SLOWCLK = ~ifc.SLOWCLK;
        e.rise = ifc.SLOWCLK;
        e.due  = cyc + LAT;
        e.hp   = hp;
        e.lk   = lk;
        e.lost = 1'b0;
        sb.push_back(e);
        last_tog = cyc;
    endtask

    // Scoreboard consumer.
    always @(negedge CLOCK) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            check("pulse_missing", 32'(cyc), 32'(sb[0].due));
            void'(sb.pop_front());
        end
        if (ifc.RISE || ifc.FALL) begin
            check("pulse_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check("pulse_cycle", 32'(cyc),             32'(cur.due));
                check("pulse_rise",  32'(ifc.RISE),        32'(cur.rise));
                check("pulse_fall",  32'(ifc.FALL),        32'(!cur.rise));
                check("half_period", 32'(ifc.HALF_PERIOD), 32'(cur.hp));
                check("locked",      32'(ifc.LOCKED),      32'(cur.lk));
                check("lost",        32'(ifc.LOST),        32'(cur.lost));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with the wave already high; release must not create an edge.
        ifc.SLOWCLK = 1'b1;
        RESET       = 1'b1;
        repeat (3) @(negedge CLOCK);
        check_all_zero("reset");
        RESET = 1'b0;
        repeat (20) @(negedge CLOCK);
        check_all_zero("prime");

        // Clean half-period 10: reference on edge 2, lock on edge 4.
        step(5,  0,  1'b0);
        step(10, 10, 1'b0);
        step(10, 10, 1'b0);
        step(10, 10, 1'b1);

        // Wander within TOL of each previous interval keeps lock.
        step(11, 11, 1'b1);
        step(10, 10, 1'b1);
        step(9,  9,  1'b1);
        step(10, 10, 1'b1);

        // Step to 14: lock drops on that edge, returns after two more 14s.
        step(14, 14, 1'b0);
        step(14, 14, 1'b0);
        step(14, 14, 1'b1);

        // Input stops: LOST exactly 40 cycles after the last pulse.
        while (cyc < last_tog + LAT + 39) @(negedge CLOCK);
        check("lost_early",       32'(ifc.LOST),   32'd0);
        check("locked_before_to", 32'(ifc.LOCKED), 32'd1);
        @(negedge CLOCK);
        check("lost_at_timeout",  32'(ifc.LOST),        32'd1);
        check("locked_at_timeout",32'(ifc.LOCKED),      32'd0);
        check("hp_at_timeout",    32'(ifc.HALF_PERIOD), 32'd14);

        // Resume: first edge leaves HALF_PERIOD alone, then relock at 10.
        step(7,  14, 1'b0);
        step(10, 10, 1'b0);
        step(10, 10, 1'b0);
        step(10, 10, 1'b1);

        // Edge on the very cycle the timeout would fire: edge wins.
        step(40, 40, 1'b0);
        step(40, 40, 1'b0);
        step(40, 40, 1'b1);
        repeat (LAT + 2) @(negedge CLOCK);
        check("lost_after_edge_wins", 32'(ifc.LOST), 32'd0);
        check("sb_drained_1", 32'(sb.size()), 32'd0);

        // Reset mid-operation (wave high again): everything cleared next cycle.
        RESET = 1'b1;
        @(negedge CLOCK);
        check_all_zero("midreset");
        repeat (2) @(negedge CLOCK);
        RESET = 1'b0;
        repeat (15) @(negedge CLOCK);
        check_all_zero("reprime");

        // Relock at 6, then down to the minimum half-period of 2.
        step(5, 0, 1'b0);
        step(6, 6, 1'b0);
        step(6, 6, 1'b0);
        step(6, 6, 1'b1);
        step(2, 2, 1'b0);
        step(2, 2, 1'b0);
        step(2, 2, 1'b1);

`ifdef CLK_MON_GLITCH_FILTER_EN
        // Single-cycle high glitch on a low wave must vanish.
        repeat (LAT + 2) @(negedge CLOCK);
        ifc.SLOWCLK = 1'b1;
        @(negedge CLOCK);
        ifc.SLOWCLK = 1'b0;
        repeat (10) @(negedge CLOCK);
        check("glitch_locked", 32'(ifc.LOCKED),      32'd1);
        check("glitch_hp",     32'(ifc.HALF_PERIOD), 32'd2);
        // Clean edge 20 cycles after the last real one, pulse after 5 cycles.
        step(20 - (cyc - last_tog), 20, 1'b0);
`endif

        repeat (LAT + 2) @(negedge CLOCK);
        check("sb_drained_2", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
